// File: rtl/rggen_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_bus_arbiter
//
// Shares one register-block host bus between HOSTS independent requesters.
// A pending request is picked (round-robin or fixed priority), registered
// into the downstream o_bus_* flops one cycle later, and held there until the
// downstream side answers with i_bus_ready. The completion is routed back to
// the granted requester only, as a one-cycle o_host_ready pulse.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_host_valid        per-host request pending (held until its ready)
//   i_host_access       per-host access type, 2 bits each
//   i_host_address      per-host address, ADDRESS_WIDTH bits each
//   i_host_write_data   per-host write data, BUS_WIDTH bits each
//   i_host_strobe       per-host byte strobe, BUS_WIDTH/8 bits each
//   o_host_ready        one-hot completion pulse towards the granted host
//   o_host_status       response status (broadcast, valid with ready)
//   o_host_read_data    read data (broadcast, valid with ready)
//   o_bus_*             registered downstream request
//   i_bus_ready         downstream completion
//   i_bus_status        downstream status
//   i_bus_read_data     downstream read data
// ---------------------------------------------------------------------------
module rggen_bus_arbiter #(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [HOSTS-1:0]             i_host_valid,
  input  logic [2*HOSTS-1:0]           i_host_access,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]   i_host_write_data,
  input  logic [HOSTS*BUS_WIDTH/8-1:0] i_host_strobe,
  output logic [HOSTS-1:0]             o_host_ready,
  output logic [1:0]                   o_host_status,
  output logic [BUS_WIDTH-1:0]         o_host_read_data,
  output logic                         o_bus_valid,
  output logic [1:0]                   o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]     o_bus_address,
  output logic [BUS_WIDTH-1:0]         o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]       o_bus_strobe,
  input  logic                         i_bus_ready,
  input  logic [1:0]                   i_bus_status,
  input  logic [BUS_WIDTH-1:0]         i_bus_read_data
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int IDX_W  = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic                     capture;
  logic                     complete;
  logic                     found;
  logic [IDX_W-1:0]         winner_idx;
  logic [HOSTS-1:0]         grant_next;
  logic [HOSTS-1:0]         grant_reg;
  logic [IDX_W-1:0]         win_idx_reg;
  // Index where the next round-robin search begins, i.e. last winner + 1.
  // Storing the start index rather than the winner lets reset mean "start at 0".
  logic [IDX_W-1:0]         rr_start_reg;
  logic [IDX_W-1:0]         rr_start_next;

  logic [1:0]               bus_access_reg;
  logic [ADDRESS_WIDTH-1:0] bus_address_reg;
  logic [BUS_WIDTH-1:0]     bus_write_data_reg;
  logic [STRB_W-1:0]        bus_strobe_reg;

  // Per-host views of the flattened request buses.
  logic [1:0]               host_access     [HOSTS];
  logic [ADDRESS_WIDTH-1:0] host_address    [HOSTS];
  logic [BUS_WIDTH-1:0]     host_write_data [HOSTS];
  logic [STRB_W-1:0]        host_strobe     [HOSTS];

  for (genvar gi = 0; gi < HOSTS; gi++) begin : g_host
    assign host_access[gi]     = i_host_access[2*gi +: 2];
    assign host_address[gi]    = i_host_address[ADDRESS_WIDTH*gi +: ADDRESS_WIDTH];
    assign host_write_data[gi] = i_host_write_data[BUS_WIDTH*gi +: BUS_WIDTH];
    assign host_strobe[gi]     = i_host_strobe[STRB_W*gi +: STRB_W];
  end

  // Winner search: walk HOSTS positions starting at the search start index,
  // wrapping once; the first pending request wins. Fixed priority simply
  // always starts at 0.
  always_comb begin
    int start;
    int idx;
    found      = 1'b0;
    winner_idx = '0;
    idx        = 0;
    start      = (FIXED_PRIORITY != 0) ? 0 : int'(rr_start_reg);
    for (int k = 0; k < HOSTS; k++) begin
      idx = start + k;
      if (idx >= HOSTS) begin
        idx = idx - HOSTS;
      end
      if (!found && i_host_valid[IDX_W'(idx)]) begin
        found      = 1'b1;
        winner_idx = IDX_W'(idx);
      end
    end
    grant_next             = '0;
    grant_next[winner_idx] = 1'b1;
  end

  always_comb begin
    if (int'(win_idx_reg) + 1 >= HOSTS) begin
      rr_start_next = '0;
    end else begin
      rr_start_next = win_idx_reg + IDX_W'(1);
    end
  end

  // Next-state logic. Ready seen in IDLE is deliberately ignored.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_bus_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg          <= IDLE;
      grant_reg          <= '0;
      win_idx_reg        <= '0;
      rr_start_reg       <= '0;
      bus_access_reg     <= '0;
      bus_address_reg    <= '0;
      bus_write_data_reg <= '0;
      bus_strobe_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        // The request is frozen here; later changes on the host side
        // (including an early valid drop) do not affect this transaction.
        grant_reg          <= grant_next;
        win_idx_reg        <= winner_idx;
        bus_access_reg     <= host_access[winner_idx];
        bus_address_reg    <= host_address[winner_idx];
        bus_write_data_reg <= host_write_data[winner_idx];
        bus_strobe_reg     <= host_strobe[winner_idx];
      end
      if (complete) begin
        rr_start_reg <= rr_start_next;
      end
    end
  end

  // The downstream request is valid exactly while BUSY, which gives the
  // 1-cycle valid latency and the mandatory IDLE cycle between transactions.
  assign o_bus_valid      = (state_reg == BUSY);
  assign o_bus_access     = bus_access_reg;
  assign o_bus_address    = bus_address_reg;
  assign o_bus_write_data = bus_write_data_reg;
  assign o_bus_strobe     = bus_strobe_reg;

  assign o_host_ready     = ((state_reg == BUSY) && i_bus_ready) ? grant_reg : '0;
  assign o_host_status    = i_bus_status;
  assign o_host_read_data = i_bus_read_data;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for rggen_bus_arbiter. Two instances share the host-side stimulus:
// one round-robin, one fixed priority; 'sel' routes requests to one of them
// and picks whose outputs are observed. Expected downstream requests are
// queued when stimulus is set up and popped when o_bus_valid appears.
// ---------------------------------------------------------------------------
module tb_rggen_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic [1:0]  host_valid;
  logic [3:0]  host_access;
  logic [15:0] host_address;
  logic [63:0] host_write_data;
  logic [7:0]  host_strobe;
  logic        bus_ready;
  logic [1:0]  bus_status;
  logic [31:0] bus_read_data;

  logic [1:0]  rr_valid_in, fp_valid_in;
  logic        rr_bus_ready_in, fp_bus_ready_in;

  logic [1:0]  rr_host_ready, fp_host_ready;
  logic [1:0]  rr_host_status, fp_host_status;
  logic [31:0] rr_host_read_data, fp_host_read_data;
  logic        rr_bus_valid, fp_bus_valid;
  logic [1:0]  rr_bus_access, fp_bus_access;
  logic [7:0]  rr_bus_address, fp_bus_address;
  logic [31:0] rr_bus_write_data, fp_bus_write_data;
  logic [3:0]  rr_bus_strobe, fp_bus_strobe;

  assign rr_valid_in     = sel ? 2'b00 : host_valid;
  assign fp_valid_in     = sel ? host_valid : 2'b00;
  assign rr_bus_ready_in = sel ? 1'b0 : bus_ready;
  assign fp_bus_ready_in = sel ? bus_ready : 1'b0;

  wire [1:0]  host_ready     = sel ? fp_host_ready     : rr_host_ready;
  wire [1:0]  host_status    = sel ? fp_host_status    : rr_host_status;
  wire [31:0] host_read_data = sel ? fp_host_read_data : rr_host_read_data;
  wire        bus_valid      = sel ? fp_bus_valid      : rr_bus_valid;
  wire [1:0]  bus_access     = sel ? fp_bus_access     : rr_bus_access;
  wire [7:0]  bus_address    = sel ? fp_bus_address    : rr_bus_address;
  wire [31:0] bus_write_data = sel ? fp_bus_write_data : rr_bus_write_data;
  wire [3:0]  bus_strobe     = sel ? fp_bus_strobe     : rr_bus_strobe;

  rggen_bus_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .FIXED_PRIORITY(0)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(rr_valid_in), .i_host_access(host_access),
    .i_host_address(host_address), .i_host_write_data(host_write_data),
    .i_host_strobe(host_strobe),
    .o_host_ready(rr_host_ready), .o_host_status(rr_host_status),
    .o_host_read_data(rr_host_read_data),
    .o_bus_valid(rr_bus_valid), .o_bus_access(rr_bus_access),
    .o_bus_address(rr_bus_address), .o_bus_write_data(rr_bus_write_data),
    .o_bus_strobe(rr_bus_strobe),
    .i_bus_ready(rr_bus_ready_in), .i_bus_status(bus_status),
    .i_bus_read_data(bus_read_data)
  );

  rggen_bus_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .FIXED_PRIORITY(1)) u_fp (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(fp_valid_in), .i_host_access(host_access),
    .i_host_address(host_address), .i_host_write_data(host_write_data),
    .i_host_strobe(host_strobe),
    .o_host_ready(fp_host_ready), .o_host_status(fp_host_status),
    .o_host_read_data(fp_host_read_data),
    .o_bus_valid(fp_bus_valid), .o_bus_access(fp_bus_access),
    .o_bus_address(fp_bus_address), .o_bus_write_data(fp_bus_write_data),
    .o_bus_strobe(fp_bus_strobe),
    .i_bus_ready(fp_bus_ready_in), .i_bus_status(bus_status),
    .i_bus_read_data(bus_read_data)
  );

  typedef struct {
    int          host;
    logic [1:0]  acc;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;
  } exp_t;

  exp_t sb[$];
  int   remaining [2];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_host(input int h, input logic [1:0] acc, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, input int n);
    host_access[2*h +: 2]      = acc;
    host_address[8*h +: 8]     = addr;
    host_write_data[32*h +: 32] = wd;
    host_strobe[4*h +: 4]      = st;
    remaining[h]               = n;
    host_valid[h]              = (n > 0);
  endtask

  task automatic push(input int h, input logic [1:0] acc, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    e.host = h; e.acc = acc; e.addr = addr; e.wd = wd; e.st = st;
    sb.push_back(e);
  endtask

  // Wait for the next downstream request, compare it against the scoreboard,
  // answer after 'lat' cycles and check the response routing.
  task automatic serve(input int lat, input logic [1:0] st, input logic [31:0] rd);
    int   n;
    exp_t e;
    n = 0;
    while (bus_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus_valid !== 1'b1) begin
      check_eq("bus_valid_timeout", 32'(bus_valid), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check_eq("unexpected_bus_request", 32'(bus_valid), 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq("bus_address", 32'(bus_address), 32'(e.addr));
    check_eq("bus_access", 32'(bus_access), 32'(e.acc));
    check_eq("bus_write_data", bus_write_data, e.wd);
    check_eq("bus_strobe", 32'(bus_strobe), 32'(e.st));
    for (int i = 0; i < lat; i++) begin
      tick();
      check_eq("bus_valid_held", 32'(bus_valid), 32'd1);
      check_eq("bus_address_held", 32'(bus_address), 32'(e.addr));
      check_eq("no_early_ready", 32'(host_ready), 32'd0);
    end
    bus_ready     = 1'b1;
    bus_status    = st;
    bus_read_data = rd;
    #1;
    check_eq("host_ready", 32'(host_ready), 32'd1 << e.host);
    check_eq("host_status", 32'(host_status), 32'(st));
    check_eq("host_read_data", host_read_data, rd);
    $display("txn: dut=%s host%0d acc=%0d addr=0x%02h wdata=0x%08h lat=%0d -> ready=%b status=%0d rdata=0x%08h",
             sel ? "fp" : "rr", e.host, bus_access, bus_address, bus_write_data, lat,
             host_ready, host_status, host_read_data);
    tick();
    check_eq("ready_single_pulse", 32'(host_ready), 32'd0);
    check_eq("bus_valid_dropped", 32'(bus_valid), 32'd0);
    bus_ready = 1'b0;
    remaining[e.host]--;
    if (remaining[e.host] <= 0) host_valid[e.host] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; host_valid = '0; host_access = '0; host_address = '0;
    host_write_data = '0; host_strobe = '0; bus_ready = 1'b0; bus_status = '0;
    bus_read_data = '0; remaining[0] = 0; remaining[1] = 0;
    tick(); tick();

    // Reset state
    check_eq("rst_bus_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_bus_access", 32'(bus_access), 32'd0);
    check_eq("rst_bus_address", 32'(bus_address), 32'd0);
    check_eq("rst_bus_write_data", bus_write_data, 32'd0);
    check_eq("rst_bus_strobe", 32'(bus_strobe), 32'd0);
    check_eq("rst_host_ready", 32'(host_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Single read from host0, 1-cycle valid latency, ready 2 cycles later
    set_host(0, 2'b00, 8'h10, 32'h0, 4'h0, 1);
    push(0, 2'b00, 8'h10, 32'h0, 4'h0);
    #1;
    check_eq("latency_not_yet", 32'(bus_valid), 32'd0);
    tick();
    check_eq("latency_one_cycle", 32'(bus_valid), 32'd1);
    serve(2, 2'b00, 32'hCAFE_0001);

    // Round-robin from a fresh reset, both hosts held for three rounds
    pulse_reset();
    set_host(0, 2'b01, 8'h04, 32'h1111_0004, 4'hF, 3);
    set_host(1, 2'b01, 8'h08, 32'h2222_0008, 4'h3, 3);
    for (int r = 0; r < 3; r++) begin
      push(0, 2'b01, 8'h04, 32'h1111_0004, 4'hF);
      push(1, 2'b01, 8'h08, 32'h2222_0008, 4'h3);
    end
    for (int r = 0; r < 6; r++) begin
      serve(r % 3, 2'b00, 32'h0000_0000 + r);
    end

    // Error status on a host1 write
    set_host(1, 2'b01, 8'h0C, 32'hDEAD_BEEF, 4'hC, 1);
    push(1, 2'b01, 8'h0C, 32'hDEAD_BEEF, 4'hC);
    serve(1, 2'b10, 32'h5555_AAAA);

    // Ready while IDLE is ignored
    bus_ready = 1'b1;
    tick();
    check_eq("idle_ready_no_state_change", 32'(bus_valid), 32'd0);
    check_eq("idle_ready_no_host_ready", 32'(host_ready), 32'd0);
    set_host(0, 2'b00, 8'h20, 32'h0, 4'h0, 1);
    push(0, 2'b00, 8'h20, 32'h0, 4'h0);
    #1;
    check_eq("idle_ready_with_valid", 32'(host_ready), 32'd0);
    @(negedge clk);
    bus_ready = 1'b0;
    tick();
    check_eq("idle_ready_latency", 32'(bus_valid), 32'd1);
    serve(0, 2'b00, 32'h1234_5678);

    // Reset while BUSY; host0 last won so without reset host1 would go first
    set_host(0, 2'b00, 8'h30, 32'h0, 4'h0, 1);
    tick();
    check_eq("busy_before_reset", 32'(bus_valid), 32'd1);
    check_eq("busy_addr_before_reset", 32'(bus_address), 32'h30);
    bus_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("reset_bus_valid_now", 32'(bus_valid), 32'd0);
    check_eq("reset_host_ready_now", 32'(host_ready), 32'd0);
    check_eq("reset_bus_address_now", 32'(bus_address), 32'd0);
    tick();
    rst = 1'b0;
    bus_ready = 1'b0;
    host_valid = 2'b00;
    remaining[0] = 0;
    tick();
    set_host(0, 2'b00, 8'h40, 32'h0, 4'h0, 1);
    set_host(1, 2'b00, 8'h50, 32'h0, 4'h0, 1);
    push(0, 2'b00, 8'h40, 32'h0, 4'h0);
    push(1, 2'b00, 8'h50, 32'h0, 4'h0);
    serve(0, 2'b01, 32'h0000_000A);
    serve(0, 2'b00, 32'h0000_000B);

    // Fixed priority: host1 waits until host0 has nothing left
    sel = 1'b1;
    pulse_reset();
    set_host(0, 2'b01, 8'h60, 32'h6666_0000, 4'h1, 3);
    set_host(1, 2'b01, 8'h70, 32'h7777_0000, 4'h8, 2);
    for (int r = 0; r < 3; r++) push(0, 2'b01, 8'h60, 32'h6666_0000, 4'h1);
    for (int r = 0; r < 2; r++) push(1, 2'b01, 8'h70, 32'h7777_0000, 4'h8);
    for (int r = 0; r < 5; r++) begin
      serve(r % 2, 2'b00, 32'hF000_0000 + r);
    end

    tick();
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    check_eq("final_idle", 32'(bus_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
